k005297_loopgate: RTL
=====================

// Module: k005297_loopgate
// PURPOSE
//  Downstream consumer of the mask register's serial LSB. Per bubble-loop bit slot, gates serial
//  read data (i_BDI) with the loop mask bit: good loops (mask=1) are packed LSB-first into 16-bit
//  words; bad loops (mask=0) are skipped. Words go to the host-side data path through a 2-entry
//  valid/ready buffer. Page sequencing, overflow detection and page-done signalling are included.
// PARAMETERS
//  WORD_W      16   assembled word width; the bit counter wraps at WORD_W
//  PAGE_WORDS  32   words per page before DRAIN is entered (>=1)
// PORTS
//  i_MCLK           in   1       master clock; all state changes on posedge
//  i_RST_n          in   1       asynchronous active-low reset
//  i_CLK2M_PCEN_n   in   1       2 MHz clock enable, active low; slot sampling only
//  i_BITSLOT        in   1       one loop bit slot is present on this 2M enable
//  i_MSKREG_SR_LSB  in   1       loop mask bit for the current slot (1=good loop)
//  i_BDI            in   1       serial bubble data bit for the current slot
//  i_PAGE_START     in   1       start page (honoured in IDLE only)
//  i_ABORT          in   1       abandon the page; flush
//  o_WORD           out  WORD_W  head-of-buffer word
//  o_WORD_VLD       out  1       o_WORD valid
//  i_WORD_RDY       in   1       consumer accepts; pop when VLD&RDY on an MCLK edge
//  o_BUSY           out  1       state != IDLE
//  o_PAGE_DONE      out  1       one-MCLK pulse at page completion
//  o_OVF            out  1       sticky: word lost because buffer full
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, bit counter 0, word counter 0, buffer empty, shift reg 0.
//  States: IDLE -> COLLECT on i_PAGE_START. COLLECT -> DRAIN when word PAGE_WORDS is completed.
//  DRAIN -> IDLE when buffer empty; o_PAGE_DONE=1 for exactly that one MCLK cycle.
//  i_ABORT (any MCLK edge, priority over everything except reset): -> IDLE, flush buffer,
//  clear bit/word counters, no PAGE_DONE. o_OVF is kept.
//  i_PAGE_START while not IDLE: ignored. In IDLE it also clears o_OVF.
//  Slot capture (COLLECT, !i_CLK2M_PCEN_n & i_BITSLOT & i_MSKREG_SR_LSB):
//   - shift right, i_BDI enters bit WORD_W-1, bit counter increments. The first good bit of a
//     word therefore ends up in bit 0.
//   - On the WORD_W-th good bit, the completed word {i_BDI, sr[WORD_W-1:1]} is pushed on the
//     same edge, the bit counter wraps to 0 and the word counter increments.
//   - Mask=0 slots change nothing. Slots with i_CLK2M_PCEN_n high or outside COLLECT are ignored.
//  Buffer: 2-entry FIFO; o_WORD_VLD=!empty is registered; latency is push edge -> VLD high
//   after the same edge (one MCLK).
//   - Push and pop on the same edge when full: both take effect and no overflow occurs.
//   - Push when full without pop: word dropped, o_OVF<=1, word counter still increments
//     (page length is preserved).
//   - o_WORD is stable while VLD=1 and RDY=0.
//  Word counter: width clog2(PAGE_WORDS+1); cleared on entering COLLECT.
//  Reset asserted mid-operation: immediate return to reset values, including o_OVF.
// TESTING
//  1 Mask all 1; i_BDI carries 0xA5A5 LSB-first over 16 slots -> o_WORD=16'hA5A5, VLD one MCLK
//    after the 16th slot edge.
//  2 Mask 1,0,1,0... over 32 slots; good-slot data 0x1234 LSB-first, bad slots 1 -> o_WORD=16'h1234.
//  3 RDY=0, three words 0x0001/0x0002/0x0003 -> o_OVF=1; pops then give 0x0001, 0x0002; VLD=0.
//  4 PAGE_WORDS=4, RDY=1 -> 4 words out; o_PAGE_DONE exactly 1 cycle; o_BUSY=0 after.
//    Extra i_PAGE_START mid-page has no effect.
//  5 i_ABORT after 7 good bits -> IDLE, VLD=0; next page with 0xFFFF -> o_WORD=16'hFFFF
//    (no stale bits).
//  6 i_RST_n low mid-COLLECT, between clock edges -> all outputs 0 immediately. Full buffer push
//    with simultaneous pop -> no OVF.

Source files
------------

// File: rtl/k005297_loopgate.sv
// k005297_loopgate
//   Gates serial bubble read data with the loop mask bit. Good loops (mask=1)
//   are packed LSB-first into WORD_W-bit words. Bad loops (mask=0) are skipped.
//   Completed words leave through a 2-entry valid/ready buffer. The block also
//   sequences pages, flags overflow and signals page completion.
// Ports
//   i_MCLK, i_RST_n            master clock, async active-low reset
//   i_CLK2M_PCEN_n, i_BITSLOT  slot qualifier (enable low and slot present)
//   i_MSKREG_SR_LSB, i_BDI     loop mask bit (1=good) and serial data bit
//   i_PAGE_START, i_ABORT      page start (IDLE only) and page abandon/flush
//   o_WORD, o_WORD_VLD         head-of-buffer word and its valid flag
//   i_WORD_RDY                 consumer ready; pop when VLD & RDY
//   o_BUSY, o_PAGE_DONE        not idle, and a one-cycle page completion pulse
//   o_OVF                      sticky: a word was dropped because the buffer was full
module k005297_loopgate #(
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned PAGE_WORDS = 32
) (
   input  logic              i_MCLK,
   input  logic              i_RST_n,
   input  logic              i_CLK2M_PCEN_n,
   input  logic              i_BITSLOT,
   input  logic              i_MSKREG_SR_LSB,
   input  logic              i_BDI,
   input  logic              i_PAGE_START,
   input  logic              i_ABORT,
   output logic [WORD_W-1:0] o_WORD,
   output logic              o_WORD_VLD,
   input  logic              i_WORD_RDY,
   output logic              o_BUSY,
   output logic              o_PAGE_DONE,
   output logic              o_OVF
);

   localparam int unsigned BC_W = $clog2(WORD_W);
   localparam int unsigned WC_W = $clog2(PAGE_WORDS + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0] sr_q, sr_d;
   logic [WORD_W-1:0] mem_q [2];
   logic [WORD_W-1:0] mem_d [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic              page_done_q, page_done_d;
   logic              ovf_q, ovf_d;

   logic capture, word_done, last_word, pop, full, do_push;

   always_comb begin
      capture   = (state_q == ST_COLLECT) && !i_CLK2M_PCEN_n && i_BITSLOT && i_MSKREG_SR_LSB;
      word_done = capture && (bit_cnt_q == BC_W'(WORD_W - 1));
      last_word = word_done && (word_cnt_q == WC_W'(PAGE_WORDS - 1));
      pop       = vld_q && i_WORD_RDY;
      full      = (cnt_q == 2'd2);
      // When full, a simultaneous pop frees the slot being written this edge.
      do_push   = word_done && (!full || pop);
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_MCLK or negedge i_RST_n) begin
      if (!i_RST_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (i_ABORT) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:    if (i_PAGE_START) state_d = ST_COLLECT;
            ST_COLLECT: if (last_word)    state_d = ST_DRAIN;
            ST_DRAIN:   if (cnt_q == 2'd0) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_BUSY      = (state_q != ST_IDLE);
      o_WORD      = mem_q[rd_ptr_q];
      o_WORD_VLD  = vld_q;
      o_PAGE_DONE = page_done_q;
      o_OVF       = ovf_q;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      sr_d        = sr_q;
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      page_done_d = 1'b0;

      if (i_ABORT) begin
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         sr_d       = '0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         cnt_d      = 2'd0;
      end else begin
         if (state_q == ST_IDLE && i_PAGE_START) begin
            ovf_d      = 1'b0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
         end
         if (state_q == ST_DRAIN && cnt_q == 2'd0) page_done_d = 1'b1;

         if (capture) begin
            sr_d = {i_BDI, sr_q[WORD_W-1:1]};
            if (word_done) begin
               bit_cnt_d  = '0;
               word_cnt_d = word_cnt_q + WC_W'(1);
            end else begin
               bit_cnt_d  = bit_cnt_q + BC_W'(1);
            end
         end

         // Dropped words still count toward the page length.
         if (word_done && full && !pop) ovf_d = 1'b1;
         if (do_push) begin
            mem_d[wr_ptr_q] = sr_d;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) rd_ptr_d = ~rd_ptr_q;
         cnt_d = cnt_q + 2'(do_push) - 2'(pop);
      end
      vld_d = (cnt_d != 2'd0);
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_MCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         sr_q        <= '0;
         mem_q       <= '{default: '0};
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         vld_q       <= 1'b0;
         page_done_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         sr_q        <= sr_d;
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         vld_q       <= vld_d;
         page_done_q <= page_done_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule
